// File: rtl/shot_resolver_if.sv
// Shot resolver signal bundle: cursor/button inputs in, boards, counters and result pulse out.
interface shot_resolver_if #(
    parameter int GRID_SIZE = 10,
    parameter int HIT_W     = 5
);
    localparam int NCELL = GRID_SIZE * GRID_SIZE;

    logic [6:0]       coord;
    logic             fire;
    logic [NCELL-1:0] ship_map;
    logic [NCELL-1:0] shot_map;
    logic [NCELL-1:0] hit_map;
    logic             result_valid;
    logic             result_hit;
    logic             result_reject;
    logic [6:0]       shots;
    logic [HIT_W-1:0] hits;
    logic             busy;
    logic             game_over;

    modport master (
        output coord, fire, ship_map,
        input  shot_map, hit_map, result_valid, result_hit, result_reject,
               shots, hits, busy, game_over
    );

    modport slave (
        input  coord, fire, ship_map,
        output shot_map, hit_map, result_valid, result_hit, result_reject,
               shots, hits, busy, game_over
    );
endinterface

// File: rtl/shot_resolver.sv
// Resolves fire-button shots against the opponent ship map, tracking fired/hit boards and score.
//
// state  | meaning
// IDLE   | waiting for a fire rising edge
// CHECK  | target latched; reject if out of range or already fired on
// UPDATE | commit boards, counters and result pulse
// OVER   | every ship cell hit; frozen until rst
module shot_resolver #(
    parameter int GRID_SIZE  = 10,
    parameter int SHIP_CELLS = 17,
    parameter int HIT_W      = 5
) (
    input logic           clk,
    input logic           rst,
    shot_resolver_if.slave bus
);
    localparam int NCELL = GRID_SIZE * GRID_SIZE;
    localparam logic [6:0]       NCELL_W  = 7'(NCELL);
    localparam logic [HIT_W-1:0] SHIPS_W  = HIT_W'(SHIP_CELLS);

    typedef enum logic [1:0] {IDLE, CHECK, UPDATE, OVER} state_t;

    state_t           state_q, state_d;
    logic [6:0]       tgt_q, tgt_d;
    logic             fire_q;
    logic [NCELL-1:0] shot_map_q, shot_map_d;
    logic [NCELL-1:0] hit_map_q, hit_map_d;
    logic [6:0]       shots_q, shots_d;
    logic [HIT_W-1:0] hits_q, hits_d;
    logic             result_valid_q, result_valid_d;
    logic             result_hit_q, result_hit_d;
    logic             result_reject_q, result_reject_d;

    logic             fire_rise;
    logic             in_range;
    logic             ship_bit;
    logic             already_shot;
    logic [HIT_W-1:0] hits_sum;

    assign fire_rise    = bus.fire & ~fire_q;
    assign in_range     = tgt_q < NCELL_W;
    // Board lookups are masked so an out-of-range target never reads past the vector.
    assign ship_bit     = in_range & bus.ship_map[tgt_q];
    assign already_shot = in_range & shot_map_q[tgt_q];
    assign hits_sum     = hits_q + HIT_W'(ship_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            tgt_q           <= '0;
            fire_q          <= 1'b1;
            shot_map_q      <= '0;
            hit_map_q       <= '0;
            shots_q         <= '0;
            hits_q          <= '0;
            result_valid_q  <= 1'b0;
            result_hit_q    <= 1'b0;
            result_reject_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tgt_q           <= tgt_d;
            fire_q          <= bus.fire;
            shot_map_q      <= shot_map_d;
            hit_map_q       <= hit_map_d;
            shots_q         <= shots_d;
            hits_q          <= hits_d;
            result_valid_q  <= result_valid_d;
            result_hit_q    <= result_hit_d;
            result_reject_q <= result_reject_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tgt_d           = tgt_q;
        shot_map_d      = shot_map_q;
        hit_map_d       = hit_map_q;
        shots_d         = shots_q;
        hits_d          = hits_q;
        result_valid_d  = 1'b0;
        result_hit_d    = 1'b0;
        result_reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_rise) begin
                    tgt_d   = bus.coord;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!in_range || already_shot) begin
                    result_valid_d  = 1'b1;
                    result_reject_d = 1'b1;
                    state_d         = IDLE;
                end else begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                shot_map_d[tgt_q] = 1'b1;
                hit_map_d[tgt_q]  = ship_bit;
                shots_d           = shots_q + 7'd1;
                hits_d            = hits_sum;
                result_valid_d    = 1'b1;
                result_hit_d      = ship_bit;
                state_d           = (hits_sum == SHIPS_W) ? OVER : IDLE;
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.shot_map      = shot_map_q;
    assign bus.hit_map       = hit_map_q;
    assign bus.shots         = shots_q;
    assign bus.hits          = hits_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.result_hit    = result_hit_q;
    assign bus.result_reject = result_reject_q;
    assign bus.busy          = (state_q == CHECK) || (state_q == UPDATE);
    assign bus.game_over     = (state_q == OVER);
endmodule
